// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: stage state
// encoding plus control/data bundle layouts for each CPU stage boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // ID/EX control bundle field offsets
  localparam int ID_EX_ALUOP_LSB    = 0;
  localparam int ID_EX_ALUOP_W      = 4;
  localparam int ID_EX_ALUSRC_BIT   = 4;
  localparam int ID_EX_REGDST_BIT   = 5;
  localparam int ID_EX_BRANCH_BIT   = 6;
  localparam int ID_EX_MEMREAD_BIT  = 7;
  localparam int ID_EX_MEMWRITE_BIT = 8;
  localparam int ID_EX_MEMTOREG_BIT = 9;
  localparam int ID_EX_REGWRITE_BIT = 10;
  localparam int ID_EX_JUMP_BIT     = 11;
  localparam int ID_EX_CTRL_W       = 12;

  // EX/MEM and MEM/WB carry only the fields still needed downstream
  localparam int EX_MEM_MEMREAD_BIT  = 0;
  localparam int EX_MEM_MEMWRITE_BIT = 1;
  localparam int EX_MEM_MEMTOREG_BIT = 2;
  localparam int EX_MEM_REGWRITE_BIT = 3;
  localparam int EX_MEM_CTRL_W       = 4;

  localparam int MEM_WB_MEMTOREG_BIT = 0;
  localparam int MEM_WB_REGWRITE_BIT = 1;
  localparam int MEM_WB_CTRL_W       = 2;

  // Data bundle widths per boundary
  localparam int IF_ID_DATA_W  = 48;
  localparam int ID_EX_DATA_W  = 64;
  localparam int EX_MEM_DATA_W = 56;
  localparam int MEM_WB_DATA_W = 40;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid flag plus control and data registers.
// Clear drops valid and ctrl but keeps data; clear beats load.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      data_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      ctrl_reg  <= in_ctrl;
      data_reg  <= in_data;
    end
  end

  assign valid = valid_reg;
  assign ctrl  = ctrl_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with valid/ready handshake, flush and an
// optional two-entry skid buffer that registers in_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              acc;
  logic              rel;
  logic              m_load;
  logic              m_clear;
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_in_ctrl;
  logic [DATA_W-1:0] m_in_data;
  logic              s_valid;

  assign acc = in_valid & in_ready;
  assign rel = m_valid & out_ready;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (m_load),
    .clear   (m_clear),
    .in_ctrl (m_in_ctrl),
    .in_data (m_in_data),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  generate
    if (SKID) begin : g_skid
      stage_state_t      state_reg, state_next;
      logic              in_ready_reg;
      logic              s_load, s_clear, m_from_skid;
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (s_load),
        .clear   (s_clear),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .valid   (s_valid),
        .ctrl    (s_ctrl),
        .data    (s_data)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg    <= ST_EMPTY;
          in_ready_reg <= 1'b1;
        end else begin
          state_reg    <= state_next;
          in_ready_reg <= (state_next != ST_FULL);
        end
      end

      always_comb begin
        state_next  = state_reg;
        m_load      = 1'b0;
        m_clear     = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        m_from_skid = 1'b0;
        if (flush) begin
          state_next = ST_EMPTY;
          m_clear    = 1'b1;
          s_clear    = 1'b1;
        end else begin
          case (state_reg)
            ST_EMPTY: if (acc) begin
              state_next = ST_ONE;
              m_load     = 1'b1;
            end
            ST_ONE: begin
              if (acc && rel) begin
                m_load = 1'b1;
              end else if (acc) begin
                state_next = ST_FULL;
                s_load     = 1'b1;
              end else if (rel) begin
                state_next = ST_EMPTY;
                m_clear    = 1'b1;
              end
            end
            ST_FULL: if (rel) begin
              state_next  = ST_ONE;
              m_load      = 1'b1;
              m_from_skid = 1'b1;
              s_clear     = 1'b1;
            end
            default: state_next = ST_EMPTY;
          endcase
        end
      end

      assign in_ready  = in_ready_reg;
      assign m_in_ctrl = m_from_skid ? s_ctrl : in_ctrl;
      assign m_in_data = m_from_skid ? s_data : in_data;
    end else begin : g_pass
      // Ready passes straight through from downstream
      assign in_ready  = ~m_valid | out_ready;
      assign m_load    = acc & ~flush;
      assign m_clear   = flush | (rel & ~acc);
      assign m_in_ctrl = in_ctrl;
      assign m_in_data = in_data;
      assign s_valid   = 1'b0;
    end
  endgenerate

  // Bubbles never present live control bits (RegWrite/MemWrite)
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with SKID=1 and SKID=0 instances;
// a queue scoreboard checks every released entry against accepted inputs.
module tb_pipe_stage_skid;

  localparam int CW = 12;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  logic          z_flush, z_in_valid, z_out_ready;
  logic [CW-1:0] z_in_ctrl;
  logic [DW-1:0] z_in_data;
  logic          z_in_ready, z_out_valid;
  logic [CW-1:0] z_out_ctrl;
  logic [DW-1:0] z_out_data;
  logic [1:0]    z_occupancy;

  int total = 0;
  int bad   = 0;
  logic [CW+DW-1:0] sq[$];
  logic [CW+DW-1:0] zq[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut_z (
    .clk(clk), .rst(rst), .flush(z_flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_ctrl(z_in_ctrl), .in_data(z_in_data), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_ctrl(z_out_ctrl), .out_data(z_out_data), .occupancy(z_occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs change just after posedge, so negedge sees the values the next edge will use
  always @(negedge clk) begin
    logic [CW+DW-1:0] e;
    if (rst) begin
      sq.delete();
      zq.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("s_sb_nonempty", 64'(sq.size() != 0), 64'd1);
        if (sq.size() != 0) begin
          e = sq.pop_front();
          chk("s_sb_data", out_data, e[DW-1:0]);
          chk("s_sb_ctrl", 64'(out_ctrl), 64'(e[CW+DW-1:DW]));
        end
      end
      if (flush) sq.delete();
      else if (in_valid && in_ready) sq.push_back({in_ctrl, in_data});

      if (z_out_valid && z_out_ready) begin
        chk("z_sb_nonempty", 64'(zq.size() != 0), 64'd1);
        if (zq.size() != 0) begin
          e = zq.pop_front();
          chk("z_sb_data", z_out_data, e[DW-1:0]);
          chk("z_sb_ctrl", 64'(z_out_ctrl), 64'(e[CW+DW-1:DW]));
        end
      end
      if (z_flush) zq.delete();
      else if (z_in_valid && z_in_ready) zq.push_back({z_in_ctrl, z_in_data});
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 12'hFFF; in_data = 64'h55; out_ready = 1'b1;
    z_flush = 1'b0; z_in_valid = 1'b1; z_in_ctrl = 12'hFFF; z_in_data = 64'h55; z_out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_z_out_valid", 64'(z_out_valid), 64'd0);
    rst = 1'b0; in_valid = 1'b0; z_in_valid = 1'b0;

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_ctrl = 12'(i);
      step();
      chk($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("stream_data_%0d", i), out_data, 64'(i));
      chk($sformatf("stream_occ_%0d", i), 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_drain_occ", 64'(occupancy), 64'd0);

    // Stall fills the skid entry; C offered while FULL is refused
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA; in_ctrl = 12'h00A;
    step();
    chk("stall_a_occ", 64'(occupancy), 64'd1);
    chk("stall_a_ready", 64'(in_ready), 64'd1);
    in_data = 64'hB; in_ctrl = 12'h00B;
    step();
    chk("stall_b_occ", 64'(occupancy), 64'd2);
    chk("stall_b_ready", 64'(in_ready), 64'd0);
    chk("stall_b_data", out_data, 64'hA);
    in_data = 64'hC; in_ctrl = 12'h00C;
    step();
    chk("stall_c_occ", 64'(occupancy), 64'd2);
    chk("stall_c_data", out_data, 64'hA);
    chk("stall_c_ctrl", 64'(out_ctrl), 64'h00A);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("unstall_b_data", out_data, 64'hB);
    chk("unstall_occ", 64'(occupancy), 64'd1);
    chk("unstall_ready", 64'(in_ready), 64'd1);
    step();
    chk("unstall_empty", 64'(out_valid), 64'd0);

    // Flush while FULL, with a release and a new input in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'h0F3; in_data = 64'h11;
    step();
    in_data = 64'h22;
    step();
    chk("flush_pre_occ", 64'(occupancy), 64'd2);
    flush = 1'b1; out_ready = 1'b1; in_data = 64'hDD;
    step();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_data_kept", out_data, 64'h11);
    chk("flush_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flush_no_d", 64'(out_valid), 64'd0);

    // Bubble masking after release
    in_valid = 1'b1; in_ctrl = 12'hFFF; in_data = 64'h77;
    step();
    chk("mask_live_ctrl", 64'(out_ctrl), 64'hFFF);
    in_valid = 1'b0;
    step();
    chk("mask_valid", 64'(out_valid), 64'd0);
    chk("mask_ctrl", 64'(out_ctrl), 64'd0);
    chk("mask_data_kept", out_data, 64'h77);

    // Reset while FULL discards everything
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h91;
    step();
    in_data = 64'h92;
    step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_occ", 64'(occupancy), 64'd0);
    chk("midrst_data", out_data, 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // SKID=0: combinational ready, replacement without bubbles
    z_out_ready = 1'b0; z_in_valid = 1'b1; z_in_data = 64'h31; z_in_ctrl = 12'h031;
    step();
    chk("z_hold_valid", 64'(z_out_valid), 64'd1);
    chk("z_hold_ready", 64'(z_in_ready), 64'd0);
    chk("z_hold_occ", 64'(z_occupancy), 64'd1);
    z_in_data = 64'h32; z_in_ctrl = 12'h032;
    step();
    chk("z_stall_data", z_out_data, 64'h31);
    z_out_ready = 1'b1;
    #1;
    chk("z_comb_ready", 64'(z_in_ready), 64'd1);
    step();
    chk("z_replace_data", z_out_data, 64'h32);
    chk("z_replace_valid", 64'(z_out_valid), 64'd1);
    z_in_data = 64'h33; z_in_ctrl = 12'h033;
    step();
    chk("z_replace2_data", z_out_data, 64'h33);
    z_in_valid = 1'b0;
    step();
    chk("z_drain_valid", 64'(z_out_valid), 64'd0);
    chk("z_drain_ctrl", 64'(z_out_ctrl), 64'd0);
    chk("z_drain_occ", 64'(z_occupancy), 64'd0);

    step();
    chk("s_sb_empty", 64'(sq.size()), 64'd0);
    chk("z_sb_empty", 64'(zq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, generalised successor to the fixed per-field pipeline latches between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries two independent buses with a valid/ready handshake:
  - a control bus, forced to zero whenever the stage holds a bubble;
  - a data bus, never masked.
- Also supports synchronous flush and an optional 2-entry skid buffer that cuts the combinational ready path between stages.
- Instantiated once per pipeline boundary. The hazard unit drives out_ready (stall) and flush.

Parameters:
- CTRL_W, 12, width of the control bundle (ALUOp, MemtoReg, MemWrite, RegWrite, ...); zeroed on bubble.
- DATA_W, 64, width of the data bundle (operands, PC+2, register IDs, immediate); held, never masked.
- SKID, 1, 1 = two entries with registered in_ready; 0 = single entry with pass-through ready.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous squash of all held entries.
- in_valid, input, 1, upstream entry valid.
- in_ready, output, 1, stage can accept this cycle.
- in_ctrl, input, CTRL_W, upstream control bundle.
- in_data, input, DATA_W, upstream data bundle.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, downstream accepts (0 = stall).
- out_ctrl, output, CTRL_W, head control; 0 when out_valid = 0.
- out_data, output, DATA_W, head data; retains the last value when invalid.
- occupancy, output, 2, entries held (0..2; max 1 when SKID = 0).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
  - Reset clears both entry valids, ctrl registers and data registers to 0.
  - After reset: out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0.
  - in_ready = 1 from the first cycle after reset.
- Storage: main entry (M, drives the outputs) and skid entry (S, present only when SKID = 1).
- Accept and release:
  - acc = in_valid & in_ready.
  - rel = out_valid & out_ready.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Full throughput is 1 entry per cycle.
- SKID=1 state machine, states EMPTY / ONE / FULL:
  - EMPTY, acc -> ONE (M <= in).
  - ONE, acc & rel -> ONE (M <= in).
  - ONE, acc & ~rel -> FULL (S <= in).
  - ONE, ~acc & rel -> EMPTY.
  - FULL, rel -> ONE (M <= S). in_ready is 0 in FULL, so acc cannot occur there.
  - No other transition changes state.
- in_ready when SKID=1: in_ready = (state != FULL), driven from a flop. There is no combinational path from out_ready.
- SKID=0:
  - in_ready = ~M.valid | out_ready (combinational).
  - acc loads M.
  - rel & ~acc clears M.valid.
- Stall: while out_ready = 0, M's valid, ctrl and data remain bit-identical every cycle. Entries are never reordered, dropped or duplicated.
- Flush:
  - Synchronous, highest priority after rst.
  - Next state is EMPTY; valids and ctrl are zeroed; data registers are left unchanged.
  - An input presented in the same cycle is discarded, even if in_ready = 1.
  - A release in the same cycle still counts downstream, because out_valid was already 1.
- Bubble masking: out_ctrl = M.valid ? M.ctrl : 0. This guarantees that RegWrite and MemWrite are never asserted for a bubble.
- occupancy = M.valid + S.valid.
- Reset mid-transfer overrides everything; no entry survives.

Decomposition:
- Shared package pipe_pkg:
  - typedef for the stage state (EMPTY, ONE, FULL);
  - localparams for the ctrl bundle field offsets of each boundary (ID_EX_CTRL_W, EX_MEM_CTRL_W, ...) and the data bundle widths.
- Sub-module pipe_entry:
  - one valid + ctrl + data register with load and clear enables;
  - instantiated as M and S; S generated only when SKID = 1.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in_valid = 1 and in_ctrl = 12'hFFF -> out_valid = 0, out_ctrl = 0, out_data = 0, occupancy = 0, in_ready = 1.
- Streaming: send data 1..8 back-to-back with out_ready = 1 -> out_data shows 1..8 on consecutive cycles with 1-cycle latency; occupancy stays 1; no gaps.
- Stall with skid (SKID=1):
  - Input: A = 64'hA, then B = 64'hB; out_ready = 0 for 3 cycles.
  - Expected: occupancy goes to 2, in_ready = 0, out_data holds A; after out_ready = 1, A then B appear in order.
  - Input C offered while FULL is not accepted.
- Flush:
  - Input: stage FULL with ctrl = 12'h0F3; assert flush together with in_valid = 1 carrying D.
  - Expected: next cycle out_valid = 0, out_ctrl = 0, occupancy = 0; D is never output.
- SKID=0 pass-through:
  - out_ready = 0 with M valid -> in_ready = 0 in the same cycle.
  - Assert out_ready = 1 and in_valid = 1 in the same cycle -> M replaced, zero bubbles.
- Bubble masking: ctrl = 12'hFFF accepted, then released with no new input -> out_valid = 0 and out_ctrl = 0, while out_data keeps its last value.
